mod5_seq_monitor: RTL and testbench

//  Downstream consumer of the 3-bit mod-5 synchronous counter. Samples the count,

---
 rtl/mod5_seq_monitor.sv | 132 +++++++++++++
 tb/tb_mod5_seq_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod5_seq_monitor.sv
// rtl/mod5_seq_monitor.sv - sequence monitor for a 3-bit mod-5 counter with wrap and error reporting

module mod5_seq_monitor #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        cnt_in,
  input  logic              clr_err,
  output logic              locked,
  output logic              wrap_tick,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_illegal,
  output logic              err_seq,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          prev;
  logic [2:0]          prev_nxt;
  logic [2:0]          expected;
  logic                is_illegal;
  logic                tick_nxt;
  logic                ill_nxt;
  logic                seq_nxt;
  logic                err_event;
  logic [WRAP_W-1:0]   wrap_count_nxt;
  logic                sticky_nxt;
  logic [ERR_W-1:0]    err_count_nxt;

  // locked comes straight from the state flop, so it is registered like every other output
  assign locked = (state == LOCKED);

  // Next-state, next-prev and next-output decode for one sample
  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    tick_nxt       = 1'b0;
    ill_nxt        = 1'b0;
    seq_nxt        = 1'b0;
    wrap_count_nxt = wrap_count;
    sticky_nxt     = err_sticky;
    err_count_nxt  = err_count;

    expected   = (prev == 3'd4) ? 3'd0 : prev + 3'd1;
    is_illegal = (cnt_in > 3'd4);

    if (en) begin
      unique case (state)
        SEARCH: begin
          if (is_illegal) begin
            ill_nxt = 1'b1;
          end else if (cnt_in == 3'd0) begin
            // The locking 0 is an entry point, not a wrap
            state_nxt = LOCKED;
            prev_nxt  = 3'd0;
          end
        end
        LOCKED: begin
          if (is_illegal) begin
            // Illegal code has priority; it is never also reported as a sequence break
            state_nxt = SEARCH;
            ill_nxt   = 1'b1;
          end else if (cnt_in == expected) begin
            prev_nxt = cnt_in;
            if (prev == 3'd4) begin
              tick_nxt       = 1'b1;
              wrap_count_nxt = wrap_count + WRAP_W'(1);
            end
          end else begin
            // A mismatching 0 drops lock too; relock waits for a later sampled 0
            state_nxt = SEARCH;
            seq_nxt   = 1'b1;
          end
        end
        default: begin
          state_nxt = SEARCH;
        end
      endcase
    end

    err_event = ill_nxt | seq_nxt;

    // An error in the same cycle as clr_err wins and counts as the first event after clearing
    if (err_event) begin
      sticky_nxt = 1'b1;
      if (clr_err) begin
        err_count_nxt = ERR_W'(1);
      end else if (err_count != ERR_MAX) begin
        err_count_nxt = err_count + ERR_W'(1);
      end
    end else if (clr_err) begin
      sticky_nxt    = 1'b0;
      err_count_nxt = '0;
    end
  end

  // State, history and output registers; rst overrides every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEARCH;
      prev        <= 3'd0;
      wrap_tick   <= 1'b0;
      wrap_count  <= '0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      prev        <= prev_nxt;
      wrap_tick   <= tick_nxt;
      wrap_count  <= wrap_count_nxt;
      err_illegal <= ill_nxt;
      err_seq     <= seq_nxt;
      err_sticky  <= sticky_nxt;
      err_count   <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_mod5_seq_monitor.sv
// tb/tb_mod5_seq_monitor.sv - directed self-checking bench for mod5_seq_monitor

module tb_mod5_seq_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] cnt_in;
  logic       clr_err;
  logic       locked;
  logic       wrap_tick;
  logic [7:0] wrap_count;
  logic       err_illegal;
  logic       err_seq;
  logic       err_sticky;
  logic [3:0] err_count;

  int checks;
  int errors;
  int ticks;

  mod5_seq_monitor #(.WRAP_W(8), .ERR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cnt_in      (cnt_in),
    .clr_err     (clr_err),
    .locked      (locked),
    .wrap_tick   (wrap_tick),
    .wrap_count  (wrap_count),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .err_sticky  (err_sticky),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic e, input logic [2:0] c, input logic clr);
    rst     = 1'b0;
    en      = e;
    cnt_in  = c;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst     = 1'b1;
    en      = 1'b0;
    cnt_in  = 3'd0;
    clr_err = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_no_err(input string tag);
    check({tag, "_ill"}, err_illegal, 0);
    check({tag, "_seq"}, err_seq, 0);
    check({tag, "_sticky"}, err_sticky, 0);
    check({tag, "_cnt"}, err_count, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_tick"}, wrap_tick, 0);
    check({tag, "_wrapcnt"}, wrap_count, 0);
    check_no_err(tag);
  endtask

  initial begin
    logic [2:0] seq1 [12];
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    en      = 1'b0;
    cnt_in  = 3'd0;
    clr_err = 1'b0;

    // 1: clean run through two wraps
    do_reset(2);
    check_all_zero("t1_reset");
    seq1 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, seq1[i], 1'b0);
      check("t1_locked", locked, 1);
      check("t1_tick", wrap_tick, (i == 5 || i == 10) ? 1 : 0);
      if (wrap_tick) ticks++;
    end
    check("t1_ticks", ticks, 2);
    check("t1_wrapcnt", wrap_count, 2);
    check_no_err("t1_end");

    // 2: illegal code while locked, then relock
    do_reset(1);
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    check("t2_pre_locked", locked, 1);
    step(1'b1, 3'd6, 1'b0);
    check("t2_ill", err_illegal, 1);
    check("t2_seq", err_seq, 0);
    check("t2_locked", locked, 0);
    check("t2_sticky", err_sticky, 1);
    check("t2_cnt", err_count, 1);
    step(1'b1, 3'd3, 1'b0);
    check("t2_3_ill", err_illegal, 0);
    check("t2_3_locked", locked, 0);
    step(1'b1, 3'd0, 1'b0);
    check("t2_0_locked", locked, 1);
    step(1'b1, 3'd1, 1'b0);
    check("t2_1_locked", locked, 1);
    check("t2_1_seq", err_seq, 0);
    check("t2_1_cnt", err_count, 1);

    // 3: sequence break while locked, then relock
    do_reset(1);
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd3, 1'b0);
    check("t3_seq", err_seq, 1);
    check("t3_ill", err_illegal, 0);
    check("t3_cnt", err_count, 1);
    check("t3_locked", locked, 0);
    step(1'b1, 3'd0, 1'b0);
    check("t3_0_seq", err_seq, 0);
    check("t3_0_locked", locked, 1);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    check("t3_2_locked", locked, 1);
    check("t3_2_cnt", err_count, 1);

    // 3b: mismatching 0 drops lock and does not relock in the same sample
    step(1'b1, 3'd0, 1'b0);
    check("t3b_seq", err_seq, 1);
    check("t3b_locked", locked, 0);
    step(1'b1, 3'd0, 1'b0);
    check("t3b_relock", locked, 1);
    check("t3b_cnt", err_count, 2);

    // 4: en gaps with held values
    do_reset(1);
    step(1'b1, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b0, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd3, 1'b0);
    step(1'b0, 3'd3, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    step(1'b0, 3'd4, 1'b0);
    check("t4_gap_tick", wrap_tick, 0);
    check("t4_gap_wrapcnt", wrap_count, 0);
    step(1'b1, 3'd0, 1'b0);
    check("t4_tick", wrap_tick, 1);
    check("t4_wrapcnt", wrap_count, 1);
    step(1'b0, 3'd0, 1'b0);
    check("t4_tick_drop", wrap_tick, 0);
    check("t4_wrapcnt_hold", wrap_count, 1);
    step(1'b0, 3'd7, 1'b0);
    check("t4_en0_ill", err_illegal, 0);
    check("t4_en0_locked", locked, 1);
    check_no_err("t4_end");

    // 5: err_count saturation and clr_err interaction
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'(5 + (i % 3)), 1'b0);
      check("t5_ill", err_illegal, 1);
      check("t5_cnt", err_count, (i + 1 > 15) ? 15 : i + 1);
    end
    check("t5_sat", err_count, 15);
    check("t5_sticky", err_sticky, 1);
    step(1'b1, 3'd7, 1'b1);
    check("t5_clr_evt_cnt", err_count, 1);
    check("t5_clr_evt_sticky", err_sticky, 1);
    step(1'b0, 3'd7, 1'b1);
    check("t5_clr_cnt", err_count, 0);
    check("t5_clr_sticky", err_sticky, 0);
    check("t5_clr_ill", err_illegal, 0);

    // 6: reset mid-sequence
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1'b1, 3'(i % 5), 1'b0);
    check("t6_wrapcnt", wrap_count, 3);
    check("t6_locked", locked, 1);
    step(1'b1, 3'd1, 1'b0);
    rst     = 1'b1;
    en      = 1'b1;
    cnt_in  = 3'd2;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("t6_rst");
    step(1'b1, 3'd2, 1'b0);
    check("t6_2_locked", locked, 0);
    check("t6_2_seq", err_seq, 0);
    step(1'b1, 3'd3, 1'b0);
    check("t6_3_locked", locked, 0);
    check_no_err("t6_3");
    step(1'b1, 3'd0, 1'b0);
    check("t6_0_locked", locked, 1);
    check("t6_0_tick", wrap_tick, 0);

    // 7: wrap_count rolls over after 256 wraps
    do_reset(1);
    step(1'b1, 3'd0, 1'b0);
    for (int w = 0; w < 255; w++) begin
      for (int k = 1; k <= 5; k++) step(1'b1, 3'(k % 5), 1'b0);
    end
    check("t7_max", wrap_count, 255);
    for (int k = 1; k <= 5; k++) step(1'b1, 3'(k % 5), 1'b0);
    check("t7_roll", wrap_count, 0);
    check("t7_tick", wrap_tick, 1);
    check_no_err("t7_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
